vgpr_writeback: RTL and testbench
=================================

// Module: vgpr_writeback
// PURPOSE
//  Write-side companion to the banked VGPR read arbiter. Captures one per-thread batch of
//  results and serialises it onto the VGPR single write port, one write per cycle.
//  Splits 64-bit results at odd register addresses into two 32-bit writes.
//  Signals batch completion with a one-cycle done pulse, mirroring the read side.
// PARAMETERS
//  THREADS     4    number of per-thread result lanes
//  DATA_WIDTH  32   register width; results are 2*DATA_WIDTH
//  DEPTH       256  number of VGPRs; AW = $clog2(DEPTH)
// PORTS
//  clk       in   1                       clock
//  reset     in   1                       asynchronous, active-low reset (0 = reset)
//  wb_start  in   1                       batch capture strobe, honoured only when ~wb_busy
//  wb_mask   in   THREADS                 lanes carrying a result this batch
//  wb_addr   in   THREADS x AW            destination register per lane
//  wb_data   in   THREADS x 2*DATA_WIDTH  result per lane; [31:0] = low word
//  wb_is64   in   THREADS                 1 = 64-bit result, 0 = 32-bit (data[31:0] only)
//  waddr     out  AW                      VGPR write address
//  wdata     out  2*DATA_WIDTH            VGPR write data
//  wstrb     out  2                       VGPR word strobes {hi,lo}
//  wenable   out  1                       VGPR write enable
//  wb_busy   out  1                       batch in progress (state != IDLE)
//  wb_done   out  1                       one-cycle pulse: batch fully written
//  wb_ovf    out  1                       64-bit split at DEPTH-1 dropped its upper word; sticky
// BEHAVIOUR
//  - Reset: state IDLE; pending/buffers cleared; waddr, wdata, wstrb, wenable, wb_busy,
//    wb_done and wb_ovf all 0. Reset mid-batch abandons it; no further writes issue.
//  - Capture: wb_start while IDLE registers all lane inputs, sets pending = wb_mask and
//    clears wb_ovf. wb_start while busy is ignored, with no effect on the batch.
//  - FSM: IDLE -> ISSUE (mask != 0) or DONE (mask == 0). ISSUE -> SPLIT (odd 64-bit) or
//    stays in ISSUE. ISSUE with no pending lane left -> DONE. SPLIT -> ISSUE, or -> DONE if
//    nothing remains. DONE -> IDLE.
//  - Grant: lowest-index pending lane. Its pending bit clears in the cycle its last write issues.
//  - Write forms (wenable=1; state/buffers drive outputs, no input-to-output comb path):
//    even, 64b:    waddr=a, wdata=d, wstrb=2'b11
//    even/odd, 32b: waddr=a, wdata={32'b0,d[31:0]}, wstrb=2'b01 (VGPR places odd into hi half)
//    odd, 64b: ISSUE waddr=a, {32'b0,d[31:0]}, 2'b01; SPLIT waddr=a+1, {32'b0,d[63:32]}, 2'b01
//    odd 64b with a == DEPTH-1: SPLIT write suppressed (wenable=0); wb_ovf set
//  - Outputs are 0 whenever wenable=0.
//  - Timing: start captured at edge E; first write in cycle E+1. With N lanes and S splits,
//    writes occupy cycles E+1..E+N+S and wb_done is high in cycle E+N+S+1 (state DONE).
//    Empty mask gives wb_done in cycle E+1 with no writes.
//  - wb_busy is high in ISSUE, SPLIT and DONE. wb_start is next accepted the cycle after DONE.
// CONFIGURATION
//  VGPR_WB_PERF_EN defined: adds outputs perf_writes[15:0] and perf_splits[15:0].
//   - Both are saturating counters, reset to 0 and never cleared by wb_start.
//   - perf_writes increments on every wenable; perf_splits on every SPLIT-state write.
//  VGPR_WB_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  - Reset: hold reset=0 -> all outputs 0. Release, no start -> wenable stays 0.
//  - mask=4'b1111, even addrs 0/2/4/6, all 64b -> 4 writes (lanes 0..3, wstrb=11), done at E+5.
//  - mask=4'b0010, addr=5, is64, d=64'hAAAA_BBBB_CCCC_DDDD ->
//    5/{0,CCCCDDDD}/01, then 6/{0,AAAABBBB}/01; done at E+3.
//  - mask=4'b0001, addr=255, is64 -> one write to 255, no second write, wb_ovf=1 at done.
//    Next start clears wb_ovf.
//  - mask=0 -> no writes, wb_done at E+1. wb_start during a busy batch -> ignored, batch unchanged.
//  - Drop reset to 0 mid-batch after 1 of 3 writes -> outputs 0 immediately.
//    No writes after release. PERF (if enabled) -> perf_writes == 0.

Source files
------------

// File: rtl/vgpr_writeback.sv
// Serialises one captured per-thread batch of results onto the single VGPR write port.
// Optional performance counters are enabled by defining VGPR_WB_PERF_EN.
module vgpr_writeback #(
    parameter int THREADS    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wb_start,
    input  logic [THREADS-1:0]                     wb_mask,
    input  logic [THREADS-1:0][AW-1:0]             wb_addr,
    input  logic [THREADS-1:0][2*DATA_WIDTH-1:0]   wb_data,
    input  logic [THREADS-1:0]                     wb_is64,
    output logic [AW-1:0]                          waddr,
    output logic [2*DATA_WIDTH-1:0]                wdata,
    output logic [1:0]                             wstrb,
    output logic                                   wenable,
    output logic                                   wb_busy,
    output logic                                   wb_done,
    output logic                                   wb_ovf
`ifdef VGPR_WB_PERF_EN
    ,
    output logic [15:0]                            perf_writes,
    output logic [15:0]                            perf_splits
`endif
);

    localparam int LW = (THREADS > 1) ? $clog2(THREADS) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, SPLIT, DONE} state_t;

    state_t                                 state;
    state_t                                 next_state;
    logic [THREADS-1:0]                     pending;
    logic [THREADS-1:0][AW-1:0]             addr_q;
    logic [THREADS-1:0][2*DATA_WIDTH-1:0]   data_q;
    logic [THREADS-1:0]                     is64_q;

    logic [LW-1:0]                          grant;
    logic [THREADS-1:0]                     remaining;
    logic [AW-1:0]                          cur_addr;
    logic [2*DATA_WIDTH-1:0]                cur_data;
    logic                                   cur_is64;
    logic                                   split_needed;

    // Lowest-index pending lane wins; in SPLIT it is still pending, so it stays granted.
    always_comb begin
        grant = '0;
        for (int i = THREADS - 1; i >= 0; i--) begin
            if (pending[i]) grant = LW'(i);
        end
    end

    assign remaining    = pending & ~(THREADS'(1) << grant);
    assign cur_addr     = addr_q[grant];
    assign cur_data     = data_q[grant];
    assign cur_is64     = is64_q[grant];
    assign split_needed = cur_is64 & cur_addr[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wb_start) next_state = (wb_mask != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (pending == '0)         next_state = DONE;
                else if (split_needed)     next_state = SPLIT;
                else if (remaining != '0)  next_state = ISSUE;
                else                       next_state = DONE;
            end
            SPLIT:   next_state = (remaining != '0) ? ISSUE : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            is64_q  <= '0;
            wb_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wb_start) begin
                        pending <= wb_mask;
                        addr_q  <= wb_addr;
                        data_q  <= wb_data;
                        is64_q  <= wb_is64;
                        wb_ovf  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (!split_needed) pending <= remaining;
                end
                SPLIT: begin
                    pending <= remaining;
                    if (cur_addr == LAST_ADDR) wb_ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Write port is decoded purely from state and captured buffers.
    always_comb begin
        waddr   = '0;
        wdata   = '0;
        wstrb   = 2'b00;
        wenable = 1'b0;
        case (state)
            ISSUE: begin
                if (pending != '0) begin
                    wenable = 1'b1;
                    waddr   = cur_addr;
                    if (cur_is64 && !cur_addr[0]) begin
                        wdata = cur_data;
                        wstrb = 2'b11;
                    end else begin
                        wdata = {{DATA_WIDTH{1'b0}}, cur_data[DATA_WIDTH-1:0]};
                        wstrb = 2'b01;
                    end
                end
            end
            SPLIT: begin
                if (cur_addr != LAST_ADDR) begin
                    wenable = 1'b1;
                    waddr   = cur_addr + AW'(1);
                    wdata   = {{DATA_WIDTH{1'b0}}, cur_data[2*DATA_WIDTH-1:DATA_WIDTH]};
                    wstrb   = 2'b01;
                end
            end
            default: ;
        endcase
    end

    assign wb_busy = (state != IDLE);
    assign wb_done = (state == DONE);

`ifdef VGPR_WB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_writes <= '0;
            perf_splits <= '0;
        end else begin
            if (wenable && perf_writes != 16'hFFFF) perf_writes <= perf_writes + 16'd1;
            if (wenable && state == SPLIT && perf_splits != 16'hFFFF)
                perf_splits <= perf_splits + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vgpr_writeback.sv
// Directed self-checking bench for vgpr_writeback; checks the perf counters when
// VGPR_WB_PERF_EN is defined.
module tb_vgpr_writeback;

    logic             clk;
    logic             reset;
    logic             wb_start;
    logic [3:0]       wb_mask;
    logic [3:0][7:0]  wb_addr;
    logic [3:0][63:0] wb_data;
    logic [3:0]       wb_is64;
    logic [7:0]       waddr;
    logic [63:0]      wdata;
    logic [1:0]       wstrb;
    logic             wenable;
    logic             wb_busy;
    logic             wb_done;
    logic             wb_ovf;
`ifdef VGPR_WB_PERF_EN
    logic [15:0]      perf_writes;
    logic [15:0]      perf_splits;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  got_addr[$];
    logic [63:0] got_data[$];
    logic [1:0]  got_strb[$];

    vgpr_writeback #(.THREADS(4), .DATA_WIDTH(32), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .wb_start(wb_start), .wb_mask(wb_mask),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_is64(wb_is64),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wenable(wenable),
        .wb_busy(wb_busy), .wb_done(wb_done), .wb_ovf(wb_ovf)
`ifdef VGPR_WB_PERF_EN
        , .perf_writes(perf_writes), .perf_splits(perf_splits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at #1 after a posedge; returns in cycle E+1 of the new batch.
    task automatic apply_start(input logic [3:0] mask, input logic [3:0][7:0] addr,
                               input logic [3:0][63:0] data, input logic [3:0] is64);
        wb_mask  = mask;
        wb_addr  = addr;
        wb_data  = data;
        wb_is64  = is64;
        wb_start = 1'b1;
        @(posedge clk); #1;
        wb_start = 1'b0;
    endtask

    // Records writes from the current cycle (cycle 1) until wb_done, then steps into IDLE.
    task automatic run_batch(input int inject_cyc, output int done_cyc, output bit stray);
        got_addr.delete();
        got_data.delete();
        got_strb.delete();
        done_cyc = -1;
        stray    = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (wenable === 1'b1) begin
                got_addr.push_back(waddr);
                got_data.push_back(wdata);
                got_strb.push_back(wstrb);
            end else if (waddr !== '0 || wdata !== '0 || wstrb !== '0) begin
                stray = 1'b1;
            end
            if (cyc == inject_cyc) begin
                wb_start = 1'b1;
                wb_mask  = 4'hF;
                wb_addr  = '0;
                wb_data  = '0;
                wb_is64  = 4'hF;
            end else begin
                wb_start = 1'b0;
            end
            if (wb_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        wb_start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        wb_start = 1'b0;
        wb_mask = '0;
        wb_addr = '0;
        wb_data = '0;
        wb_is64 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({waddr, wdata, wstrb, wenable, wb_busy, wb_done, wb_ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got waddr=%0h wdata=%0h wstrb=%b we=%b busy=%b done=%b ovf=%b, expected all 0",
                     waddr, wdata, wstrb, wenable, wb_busy, wb_done, wb_ovf);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (wenable !== 1'b0 || wb_busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL idle_after_reset: got we=%b busy=%b, expected 0/0", wenable, wb_busy);
            end
        end
    endtask

    task automatic test_even64;
        logic [3:0][7:0]  a;
        logic [3:0][63:0] d;
        int done_cyc;
        bit stray;
        for (int i = 0; i < 4; i++) begin
            a[i] = 8'(2 * i);
            d[i] = {32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
        end
        apply_start(4'b1111, a, d, 4'b1111);
        run_batch(0, done_cyc, stray);
        checks++;
        if (got_addr.size() != 4 || done_cyc != 5) begin
            errors++;
            $display("[TB] FAIL even64_count: got writes=%0d done=%0d, expected 4/5", got_addr.size(), done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_addr.size() || got_addr[i] !== 8'(2 * i) ||
                got_data[i] !== {32'hA000_0000 + 32'(i), 32'h0000_1000 + 32'(i)} || got_strb[i] !== 2'b11) begin
                errors++;
                $display("[TB] FAIL even64_write%0d: got addr=%0h data=%0h strb=%b, expected addr=%0h strb=11",
                         i, got_addr[i], got_data[i], got_strb[i], 2 * i);
            end
        end
        checks++;
        if (stray !== 1'b0) begin
            errors++;
            $display("[TB] FAIL even64_idle_outputs: got nonzero outputs with wenable=0, expected 0");
        end
    endtask

    task automatic test_odd_split;
        logic [3:0][7:0]  a;
        logic [3:0][63:0] d;
        logic [7:0]  ea[2];
        logic [63:0] ed[2];
        int done_cyc;
        bit stray;
        a = {8'd40, 8'd30, 8'd5, 8'd20};
        d = '0;
        d[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        ea = '{8'd5, 8'd6};
        ed = '{64'h0000_0000_CCCC_DDDD, 64'h0000_0000_AAAA_BBBB};
        apply_start(4'b0010, a, d, 4'b1111);
        run_batch(0, done_cyc, stray);
        checks++;
        if (got_addr.size() != 2 || done_cyc != 3) begin
            errors++;
            $display("[TB] FAIL split_count: got writes=%0d done=%0d, expected 2/3", got_addr.size(), done_cyc);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (i >= got_addr.size() || got_addr[i] !== ea[i] || got_data[i] !== ed[i] || got_strb[i] !== 2'b01) begin
                errors++;
                $display("[TB] FAIL split_write%0d: got addr=%0h data=%0h strb=%b, expected addr=%0h data=%0h strb=01",
                         i, got_addr[i], got_data[i], got_strb[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_ovf;
        logic [3:0][7:0]  a;
        logic [3:0][63:0] d;
        int done_cyc;
        bit stray;
        a = '0;
        a[0] = 8'd255;
        d = '0;
        d[0] = 64'h1234_5678_9ABC_DEF0;
        apply_start(4'b0001, a, d, 4'b0001);
        // Walk to DONE manually so wb_ovf can be sampled in the done cycle.
        checks++;
        if (wenable !== 1'b1 || waddr !== 8'd255 || wdata !== 64'h0000_0000_9ABC_DEF0 || wstrb !== 2'b01) begin
            errors++;
            $display("[TB] FAIL ovf_first_write: got we=%b addr=%0h data=%0h strb=%b, expected 1/ff/9abcdef0/01",
                     wenable, waddr, wdata, wstrb);
        end
        @(posedge clk); #1;
        checks++;
        if ({wenable, waddr, wdata, wstrb} !== '0 || wb_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_split_suppressed: got we=%b addr=%0h data=%0h done=%b, expected all 0",
                     wenable, waddr, wdata, wb_done);
        end
        @(posedge clk); #1;
        checks++;
        if (wb_done !== 1'b1 || wb_ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_done: got done=%b ovf=%b, expected 1/1", wb_done, wb_ovf);
        end
        @(posedge clk); #1;
`ifdef VGPR_WB_PERF_EN
        checks++;
        if (perf_writes !== 16'd7 || perf_splits !== 16'd1) begin
            errors++;
            $display("[TB] FAIL perf_counts: got writes=%0d splits=%0d, expected 7/1", perf_writes, perf_splits);
        end
`endif
    endtask

    task automatic test_empty;
        int done_cyc;
        bit stray;
        checks++;
        if (wb_ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_sticky: got ovf=%b, expected 1", wb_ovf);
        end
        apply_start(4'b0000, '0, '0, '0);
        checks++;
        if (wb_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_cleared: got ovf=%b, expected 0", wb_ovf);
        end
        run_batch(0, done_cyc, stray);
        checks++;
        if (got_addr.size() != 0 || done_cyc != 1) begin
            errors++;
            $display("[TB] FAIL empty_batch: got writes=%0d done=%0d, expected 0/1", got_addr.size(), done_cyc);
        end
    endtask

    task automatic test_busy_ignore;
        logic [3:0][7:0]  a;
        logic [3:0][63:0] d;
        logic [7:0]  ea[4];
        logic [63:0] ed[4];
        int done_cyc;
        bit stray;
        a = {8'd3, 8'd99, 8'd7, 8'd10};
        d = {64'h5555_5555_0000_00AB, 64'h7777_7777_7777_7777,
             64'h0BAD_F00D_DEAD_BEEF, 64'hFFFF_FFFF_1234_5678};
        ea = '{8'd10, 8'd7, 8'd8, 8'd3};
        ed = '{64'h0000_0000_1234_5678, 64'h0000_0000_DEAD_BEEF,
               64'h0000_0000_0BAD_F00D, 64'h0000_0000_0000_00AB};
        apply_start(4'b1011, a, d, 4'b0010);
        run_batch(2, done_cyc, stray);
        checks++;
        if (got_addr.size() != 4 || done_cyc != 5) begin
            errors++;
            $display("[TB] FAIL busy_count: got writes=%0d done=%0d, expected 4/5", got_addr.size(), done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got_addr.size() || got_addr[i] !== ea[i] || got_data[i] !== ed[i] || got_strb[i] !== 2'b01) begin
                errors++;
                $display("[TB] FAIL busy_write%0d: got addr=%0h data=%0h strb=%b, expected addr=%0h data=%0h strb=01",
                         i, got_addr[i], got_data[i], got_strb[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int done_cyc;
        bit stray;
        logic [3:0][7:0]  a;
        logic [3:0][63:0] d;
        a = '0;
        a[0] = 8'd9;
        d = '0;
        d[0] = 64'hDEAD_0000_0000_0042;
        apply_start(4'b0000, '0, '0, '0);
        checks++;
        if (wb_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_empty_done: got done=%b, expected 1", wb_done);
        end
        // Start held through DONE: ignored there, accepted one cycle later.
        wb_mask = 4'b0001;
        wb_addr = a;
        wb_data = d;
        wb_is64 = 4'b0000;
        wb_start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (wb_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_start_in_done: got busy=%b, expected 0", wb_busy);
        end
        @(posedge clk); #1;
        wb_start = 1'b0;
        run_batch(0, done_cyc, stray);
        checks++;
        if (got_addr.size() != 1 || done_cyc != 2 || got_addr[0] !== 8'd9 ||
            got_data[0] !== 64'h0000_0000_0000_0042 || got_strb[0] !== 2'b01) begin
            errors++;
            $display("[TB] FAIL b2b_batch: got writes=%0d done=%0d addr=%0h data=%0h, expected 1/2/9/42",
                     got_addr.size(), done_cyc, got_addr[0], got_data[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0][7:0]  a;
        logic [3:0][63:0] d;
        int seen;
        a = {8'd0, 8'd14, 8'd12, 8'd10};
        d = {64'h1, 64'h2, 64'h3, 64'h4};
        apply_start(4'b0111, a, d, 4'b0111);
        checks++;
        if (wenable !== 1'b1 || waddr !== 8'd10) begin
            errors++;
            $display("[TB] FAIL midreset_first_write: got we=%b addr=%0h, expected 1/a", wenable, waddr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({waddr, wdata, wstrb, wenable, wb_busy, wb_done, wb_ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got we=%b addr=%0h busy=%b done=%b, expected all 0",
                     wenable, waddr, wb_busy, wb_done);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (wenable !== 1'b0 || wb_busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_writes: got %0d active cycles, expected 0", seen);
        end
`ifdef VGPR_WB_PERF_EN
        checks++;
        if (perf_writes !== 16'd0 || perf_splits !== 16'd0) begin
            errors++;
            $display("[TB] FAIL midreset_perf: got writes=%0d splits=%0d, expected 0/0", perf_writes, perf_splits);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_even64();
        test_odd_split();
        test_ovf();
        test_empty();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
